ship_motion_ctrl: RTL and testbench

SHIP_MOTION_CTRL -- requirements
Module: ship_motion_ctrl

---
 rtl/ship_pkg.sv | 32 +++
 rtl/ship_motion_ctrl.sv | 122 ++++++++++++
 tb/tb_ship_motion_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ship_pkg.sv
// Shared types and screen geometry for the ship movement logic.
// Also holds the per-axis step/clamp helper used to form candidate positions.
package ship_pkg;

  typedef enum logic [2:0] {IDLE, PX, CX, PY, CY} state_t;

  localparam int SHIP_W   = 32;
  localparam int SHIP_H   = 48;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [9:0] X_MAX_DEF = 10'(SCREEN_W - SHIP_W - 1);
  localparam logic [9:0] Y_MAX_DEF = 10'(SCREEN_H - SHIP_H - 1);

  // Moves one axis by step toward inc/dec, clamped to [0, max_pos]; 11-bit math avoids wrap.
  function automatic logic [9:0] next_pos(input logic [9:0] pos,
                                          input logic       inc,
                                          input logic       dec,
                                          input logic [3:0] step,
                                          input logic [9:0] max_pos);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, pos} + {7'd0, step};
    res = pos;
    if (inc && !dec)
      res = (sum > {1'b0, max_pos}) ? max_pos : sum[9:0];
    else if (dec && !inc)
      res = ({1'b0, pos} < {7'd0, step}) ? 10'd0 : (pos - {6'd0, step});
    return res;
  endfunction

endpackage

// File: rtl/ship_motion_ctrl.sv
// Per-frame ship motion: probes the collision map for x then y and commits each axis
// only when the probed location is free.
module ship_motion_ctrl
  import ship_pkg::*;
#(
  parameter logic [9:0] START_X = 10'd64,
  parameter logic [9:0] START_Y = 10'd64,
  parameter logic [3:0] STEP    = 4'd2,
  parameter logic [9:0] X_MAX   = X_MAX_DEF,
  parameter logic [9:0] Y_MAX   = Y_MAX_DEF,
  parameter int         MAP_LAT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       collision,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [9:0] ship_x,
  output logic [9:0] ship_y,
  output logic       busy,
  output logic       blocked,
  output logic       overrun
);

  localparam int CNT_W = (MAP_LAT > 2) ? $clog2(MAP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAP_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [9:0]       cand_x;
  logic [9:0]       cand_y;
  logic [9:0]       next_x;
  logic [9:0]       next_y;

  assign next_x = next_pos(ship_x, key_right, key_left, STEP, X_MAX);
  assign next_y = next_pos(ship_y, key_down,  key_up,   STEP, Y_MAX);

  // The probe address is set one state ahead so it is stable for the full map latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cand_x   <= START_X;
      cand_y   <= START_Y;
      ship_x   <= START_X;
      ship_y   <= START_Y;
      probe_x  <= START_X;
      probe_y  <= START_Y;
      busy     <= 1'b0;
      blocked  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= frame_tick && (state != IDLE);
      case (state)
        IDLE: begin
          probe_x <= ship_x;
          probe_y <= ship_y;
          if (frame_tick) begin
            cand_x   <= next_x;
            cand_y   <= next_y;
            probe_x  <= next_x;
            probe_y  <= ship_y;
            blocked  <= 1'b0;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= PX;
          end
        end
        PX: begin
          if (wait_cnt == CNT_LAST) begin
            wait_cnt <= '0;
            state    <= CX;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        CX: begin
          if (!collision) begin
            ship_x  <= cand_x;
            probe_x <= cand_x;
          end else begin
            probe_x <= ship_x;
            if (cand_x != ship_x)
              blocked <= 1'b1;
          end
          probe_y <= cand_y;
          state   <= PY;
        end
        PY: begin
          if (wait_cnt == CNT_LAST) begin
            wait_cnt <= '0;
            state    <= CY;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        CY: begin
          if (!collision) begin
            ship_y  <= cand_y;
            probe_y <= cand_y;
          end else begin
            probe_y <= ship_y;
            if (cand_y != ship_y)
              blocked <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Directed bench for ship_motion_ctrl: a scoreboard of expected end-of-frame positions
// plus per-cycle timing checks; a second instance starts at the screen corner for clamping.
module tb_ship_motion_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick, key_up, key_down, key_left, key_right, collision;
  logic [9:0] probe_x, probe_y, ship_x, ship_y;
  logic busy, blocked, overrun;
  logic [9:0] c_probe_x, c_probe_y, c_ship_x, c_ship_y;
  logic c_busy, c_blocked, c_overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {string tag; int x; int y; bit blk;} exp_t;
  exp_t sb[$];

  int mx, my;
  logic [9:0] snap_px0, snap_py0, snap_px3, snap_py3;

  always #5 clk = ~clk;

  ship_motion_ctrl dut (
    .Clk(clk), .Reset(reset), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .collision(collision), .probe_x(probe_x), .probe_y(probe_y),
    .ship_x(ship_x), .ship_y(ship_y), .busy(busy), .blocked(blocked), .overrun(overrun)
  );

  ship_motion_ctrl #(.START_X(10'd1), .START_Y(10'd431)) dut_c (
    .Clk(clk), .Reset(reset), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .collision(collision), .probe_x(c_probe_x), .probe_y(c_probe_y),
    .ship_x(c_ship_x), .ship_y(c_ship_y), .busy(c_busy), .blocked(c_blocked),
    .overrun(c_overrun)
  );

  function automatic int step_axis(int pos, bit inc, bit dec, int step, int max_pos);
    if (inc && !dec) return (pos + step > max_pos) ? max_pos : pos + step;
    if (dec && !inc) return (pos < step) ? 0 : pos - step;
    return pos;
  endfunction

  task automatic check_output(input string tag, input logic [10:0] observed,
                              input logic [10:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    collision = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mx = 64;
    my = 64;
  endtask

  // One frame: tick, then seven observed cycles. extra_e is the edge at which a second tick is sampled (-1 = none).
  task automatic apply_stimulus(input bit r, input bit l, input bit u, input bit d,
                                input bit cx_col, input bit cy_col, input bit other_col,
                                input int extra_e);
    exp_t e;
    int cand_x, cand_y, old_x, old_y;
    bit blk;
    @(negedge clk);
    key_right = r; key_left = l; key_up = u; key_down = d;
    frame_tick = 1'b1;
    collision = other_col;
    old_x = mx;
    old_y = my;
    cand_x = step_axis(mx, r, l, 2, 607);
    cand_y = step_axis(my, d, u, 2, 431);
    blk = 1'b0;
    if (!cx_col) mx = cand_x; else if (cand_x != old_x) blk = 1'b1;
    if (!cy_col) my = cand_y; else if (cand_y != old_y) blk = 1'b1;
    e.tag = "frame"; e.x = mx; e.y = my; e.blk = blk;
    sb.push_back(e);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      frame_tick = (c == extra_e - 1);
      collision = (c == 2) ? cx_col : (c == 5) ? cy_col : other_col;
      check_output("overrun", {10'd0, overrun}, {10'd0, (c == extra_e)});
      check_output("busy", {10'd0, busy}, {10'd0, (c < 6)});
      if (c == 0) begin
        check_output("blocked_cleared", {10'd0, blocked}, 11'd0);
        check_output("px_probe_y", {1'b0, probe_y}, 11'(old_y));
        snap_px0 = c_probe_x;
        snap_py0 = c_probe_y;
      end
      if (c == 2) check_output("x_before_commit", {1'b0, ship_x}, 11'(old_x));
      if (c == 3) begin
        check_output("x_commit", {1'b0, ship_x}, 11'(mx));
        check_output("y_before_commit", {1'b0, ship_y}, 11'(old_y));
        check_output("py_probe_x", {1'b0, probe_x}, 11'(mx));
        snap_px3 = c_probe_x;
        snap_py3 = c_probe_y;
      end
      if (c == 5) check_output("y_before_commit_cy", {1'b0, ship_y}, 11'(old_y));
      if (c == 6) begin
        e = sb.pop_front();
        check_output("sb_ship_x", {1'b0, ship_x}, 11'(e.x));
        check_output("sb_ship_y", {1'b0, ship_y}, 11'(e.y));
        check_output("sb_blocked", {10'd0, blocked}, {10'd0, e.blk});
        check_output("idle_probe_x", {1'b0, probe_x}, 11'(e.x));
        check_output("idle_probe_y", {1'b0, probe_y}, 11'(e.y));
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    exp_t e;
    $display("[TB] start");
    apply_reset();
    check_output("rst_ship_x", {1'b0, ship_x}, 11'd64);
    check_output("rst_ship_y", {1'b0, ship_y}, 11'd64);
    check_output("rst_probe_x", {1'b0, probe_x}, 11'd64);
    check_output("rst_probe_y", {1'b0, probe_y}, 11'd64);
    check_output("rst_busy", {10'd0, busy}, 11'd0);
    check_output("rst_blocked", {10'd0, blocked}, 11'd0);
    check_output("rst_overrun", {10'd0, overrun}, 11'd0);
    check_output("rst_c_ship_x", {1'b0, c_ship_x}, 11'd1);
    check_output("rst_c_ship_y", {1'b0, c_ship_y}, 11'd431);

    $display("[TB] clamp at left/bottom edge");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check_output("clamp_probe_x_px", {1'b0, snap_px0}, 11'd0);
    check_output("clamp_probe_y_px", {1'b0, snap_py0}, 11'd431);
    check_output("clamp_probe_x_py", {1'b0, snap_px3}, 11'd0);
    check_output("clamp_probe_y_py", {1'b0, snap_py3}, 11'd431);
    check_output("clamp_ship_x", {1'b0, c_ship_x}, 11'd0);
    check_output("clamp_ship_y", {1'b0, c_ship_y}, 11'd431);
    check_output("clamp_blocked", {10'd0, c_blocked}, 11'd0);

    apply_reset();
    $display("[TB] free move right");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check_output("free_ship_x", {1'b0, ship_x}, 11'd66);
    check_output("free_ship_y", {1'b0, ship_y}, 11'd64);

    for (int i = 0; i < 17; i++)
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check_output("at_100_x", {1'b0, ship_x}, 11'd100);
    check_output("at_100_y", {1'b0, ship_y}, 11'd100);

    $display("[TB] wall slide");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    check_output("slide_x", {1'b0, ship_x}, 11'd100);
    check_output("slide_y", {1'b0, ship_y}, 11'd102);
    check_output("slide_blocked", {10'd0, blocked}, 11'd1);
    repeat (5) @(negedge clk);
    check_output("blocked_holds", {10'd0, blocked}, 11'd1);

    $display("[TB] opposite keys against wall");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    check_output("opposite_x", {1'b0, ship_x}, 11'd100);
    check_output("opposite_y", {1'b0, ship_y}, 11'd102);

    $display("[TB] overrun mid-frame");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    repeat (10) @(negedge clk);
    check_output("overrun_single_x", {1'b0, ship_x}, 11'd102);
    check_output("overrun_idle_busy", {10'd0, busy}, 11'd0);

    $display("[TB] overrun on final edge");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    repeat (10) @(negedge clk);
    check_output("late_tick_x", {1'b0, ship_x}, 11'(mx));
    check_output("late_tick_busy", {10'd0, busy}, 11'd0);
    check_output("late_tick_overrun", {10'd0, overrun}, 11'd0);

    $display("[TB] reset during y probe");
    @(negedge clk);
    key_right = 1'b1; key_left = 1'b0; key_up = 1'b0; key_down = 1'b1;
    frame_tick = 1'b1;
    collision = 1'b0;
    e.tag = "reset_mid"; e.x = 64; e.y = 64; e.blk = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    e = sb.pop_front();
    check_output("rstmid_ship_x", {1'b0, ship_x}, 11'(e.x));
    check_output("rstmid_ship_y", {1'b0, ship_y}, 11'(e.y));
    check_output("rstmid_probe_x", {1'b0, probe_x}, 11'(e.x));
    check_output("rstmid_probe_y", {1'b0, probe_y}, 11'(e.y));
    check_output("rstmid_busy", {10'd0, busy}, 11'd0);
    check_output("rstmid_blocked", {10'd0, blocked}, {10'd0, e.blk});
    @(negedge clk);
    reset = 1'b0;
    mx = 64;
    my = 64;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check_output("after_rst_x", {1'b0, ship_x}, 11'd66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
